nios2_cpu_oci_trace_monitor: RTL and testbench
==============================================

Name: nios2_cpu_oci_trace_monitor

Overview:
- Parametrised simulation/debug-side trace monitor for the Nios II OCI block.
- Accepts packed debug-capture-trace (DCT) frames of up to SLOTS slots, unpacks them one slot per cycle into a DEPTH-entry FIFO, and drains the FIFO over a valid/ready stream.
- Tracks drops and malformed counts; handles the test-ending flush/abort sequence.
- Sits between the OCI trace path and the simulation trace consumer or on-chip debug buffer.

Parameters:
- SLOT_W, 10, width of one trace slot in bits.
- SLOTS, 3, maximum slots per frame; dct_buffer width = SLOTS*SLOT_W.
- COUNT_W, 4, width of dct_count.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- DROP_ON_FULL, 0, 0 = stall unpacking while the FIFO is full; 1 = drop the slot and count it.
- DROP_CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dct_buffer  in  SLOTS*SLOT_W  packed frame; slot 0 occupies the LSBs.
- dct_count  in  COUNT_W  number of valid slots in the frame.
- dct_valid  in  1  frame offered.
- dct_ready  out  1  frame accepted when dct_valid && dct_ready.
- test_ending  in  1  request a graceful flush.
- test_has_ended  in  1  abort: discard contents and finish immediately.
- trc_data  out  SLOT_W (+16 with option)  output slot.
- trc_valid  out  1  trc_data valid.
- trc_ready  in  1  consumer ready; transfer on trc_valid && trc_ready.
- drop_count  out  DROP_CNT_W  slots dropped; saturating.
- count_err  out  1  sticky; set when dct_count > SLOTS.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- test_done  out  1  flush/abort complete.

Behaviour:
- Reset values: dct_ready=0, trc_valid=0, trc_data=0, drop_count=0, count_err=0, fifo_level=0, test_done=0. FIFO pointers are cleared and the FSM enters IDLE. Reset mid-frame discards the frame and all FIFO contents.
- FSM states: IDLE, UNPACK, FLUSH, DONE.
- IDLE:
  - dct_ready=1 only in IDLE with test_ending=0.
  - On accept: register dct_buffer; set remaining = min(dct_count, SLOTS); slot index = 0.
  - If dct_count > SLOTS, set count_err (stays set until reset).
  - If remaining == 0, stay in IDLE (frame consumed, nothing written); otherwise go to UNPACK.
  - test_ending=1 in IDLE → FLUSH.
- UNPACK:
  - Each cycle writes slot[index] to the FIFO, then index++ and remaining--.
  - FIFO full and DROP_ON_FULL=0: hold (no write, no advance).
  - FIFO full and DROP_ON_FULL=1: discard the slot, advance, and increment drop_count (saturates at all-ones).
  - After the last slot: test_ending=1 → FLUSH, else → IDLE.
  - Per-frame latency: first slot is visible on trc_valid 2 cycles after accept (1 to unpack-write, 1 for FIFO registered output); a frame of n slots with no backpressure occupies UNPACK for n cycles.
- FIFO:
  - Registered output; trc_valid=1 whenever non-empty. trc_data holds stable while trc_valid && !trc_ready.
  - Simultaneous write and read while full: with DROP_ON_FULL=1 the write is treated as dropped (full is sampled before the read). Write and read while non-full: level unchanged.
  - Pointers wrap modulo DEPTH. fifo_level counts 0..DEPTH.
- FLUSH:
  - No new frames accepted; the FIFO drains normally.
  - When the FIFO is empty and trc_valid=0 → DONE.
- DONE:
  - test_done=1, dct_ready=0. Held until reset.
- test_has_ended=1 in any state:
  - Next cycle: FIFO emptied (trc_valid=0), in-progress frame discarded, state = DONE, test_done=1.
  - Has priority over test_ending and over a simultaneous dct_valid accept.

Optional Feature:
- Macro: NIOS2_OCI_TRACE_TSTAMP_EN.
- Defined: a free-running 16-bit cycle counter (reset to 0, wraps) is sampled at frame accept. Every slot of that frame carries the timestamp as trc_data[SLOT_W+15:SLOT_W], and FIFO width grows by 16.
- Undefined: trc_data is SLOT_W bits and no counter exists.

Test Plan:
- Frame buffer=0x3FF_155_0AA, count=3, trc_ready=1 → trc_data 0x0AA, 0x155, 0x3FF on consecutive cycles; first valid 2 cycles after accept; fifo_level returns to 0.
- count=0, then count=5 (SLOTS=3) → first writes nothing; second emits 3 slots and sets count_err=1; count_err stays 1 until reset.
- DEPTH=16, trc_ready=0, 6 frames of 3 slots:
  - DROP_ON_FULL=0: fifo_level=16, dct_ready stays low, FSM stalls in UNPACK; after trc_ready=1, all 18 slots arrive in order.
  - DROP_ON_FULL=1: drop_count=2 and slots 17–18 are missing.
- test_ending asserted during the 2nd slot of a 3-slot frame with trc_ready=1 → third slot still emitted, no further dct_ready, test_done=1 one cycle after the last transfer.
- FIFO holding 10 entries plus test_has_ended pulse → next cycle trc_valid=0, fifo_level=0, test_done=1; reset → all outputs at reset values.
- With NIOS2_OCI_TRACE_TSTAMP_EN: frames accepted at cycles 5 and 20 after reset → upper 16 bits of trc_data = 5 for every slot of frame 1 and 20 for frame 2.

Source files
------------

// File: rtl/nios2_cpu_oci_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : nios2_cpu_oci_trace_monitor
// Purpose  : Unpacks Nios II OCI debug-capture-trace (DCT) frames one slot
//            per cycle into a DEPTH-entry FIFO with a registered output and
//            drains it over a valid/ready stream. Counts dropped slots,
//            flags malformed slot counts, and runs the test-ending flush or
//            the abort sequence.
// Options  : NIOS2_OCI_TRACE_TSTAMP_EN - when defined, every slot carries the
//            16-bit cycle count captured at frame accept in
//            trc_data_o[SLOT_W+15:SLOT_W].
// Revision : 1.0 - initial release
// ============================================================================
module nios2_cpu_oci_trace_monitor #(
   parameter int SLOT_W       = 10,
   parameter int SLOTS        = 3,
   parameter int COUNT_W      = 4,
   parameter int DEPTH        = 16,
   parameter int DROP_ON_FULL = 0,
   parameter int DROP_CNT_W   = 8,
`ifdef NIOS2_OCI_TRACE_TSTAMP_EN
   localparam int TRC_W       = SLOT_W + 16,
`else
   localparam int TRC_W       = SLOT_W,
`endif
   localparam int LVL_W       = $clog2(DEPTH) + 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [SLOTS*SLOT_W-1:0] dct_buffer_i,
   input  logic [COUNT_W-1:0]      dct_count_i,
   input  logic                    dct_valid_i,
   output logic                    dct_ready_o,
   input  logic                    test_ending_i,
   input  logic                    test_has_ended_i,
   output logic [TRC_W-1:0]        trc_data_o,
   output logic                    trc_valid_o,
   input  logic                    trc_ready_i,
   output logic [DROP_CNT_W-1:0]   drop_count_o,
   output logic                    count_err_o,
   output logic [LVL_W-1:0]        fifo_level_o,
   output logic                    test_done_o
);

   localparam int                 PTR_W    = $clog2(DEPTH);
   localparam int                 REM_W    = $clog2(SLOTS + 1);
   localparam int                 BUF_W    = SLOTS * SLOT_W;
   localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(DEPTH);
   localparam logic [REM_W-1:0]   REM_MAX  = REM_W'(SLOTS);
   localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(SLOTS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UNPACK = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Control state
   state_t                  state_q, state_d;
   logic [BUF_W-1:0]        frame_q, frame_d;
   logic [REM_W-1:0]        rem_q, rem_d;
   logic [REM_W-1:0]        idx_q, idx_d;
   logic                    ending_q, ending_d;
   logic                    count_err_q, count_err_d;
   logic [DROP_CNT_W-1:0]   drop_q, drop_d;

   // FIFO storage and output stage
   logic [TRC_W-1:0]        mem_q [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]        level_q, level_d;
   logic                    trc_valid_q;
   logic [TRC_W-1:0]        trc_data_q;

   // Combinational helpers
   logic                    ending_req;
   logic                    accept;
   logic                    full;
   logic                    wr_en;
   logic                    drop_slot;
   logic                    advance;
   logic                    rd_en;
   logic [BUF_W-1:0]        frame_shifted;
   logic [SLOT_W-1:0]       cur_slot;
   logic [TRC_W-1:0]        wr_word;
   logic [REM_W-1:0]        clamp_cnt;
   logic [PTR_W-1:0]        rd_next;
   logic [PTR_W-1:0]        head_sel;

   // A test_ending pulse is remembered so a short request is never lost
   assign ending_req  = test_ending_i | ending_q;

   // Frames are only taken in IDLE, never while ending/aborting or in reset
   assign dct_ready_o = !reset_i && (state_q == ST_IDLE) && !ending_req
                        && !test_has_ended_i;
   assign accept      = dct_ready_o && dct_valid_i;

   // Full is sampled before any same-cycle read
   assign full        = (level_q == LVL_FULL);
   assign wr_en       = (state_q == ST_UNPACK) && !test_has_ended_i && !full;
   assign drop_slot   = (DROP_ON_FULL != 0) && (state_q == ST_UNPACK)
                        && !test_has_ended_i && full;
   assign advance     = wr_en | drop_slot;
   assign rd_en       = trc_valid_q && trc_ready_i;

   assign frame_shifted = frame_q >> (int'(idx_q) * SLOT_W);
   assign cur_slot      = frame_shifted[SLOT_W-1:0];
   assign clamp_cnt     = (dct_count_i > CNT_MAX) ? REM_MAX : REM_W'(dct_count_i);

   assign rd_next  = rd_ptr_q + PTR_W'(1);
   assign head_sel = rd_en ? rd_next : rd_ptr_q;

`ifdef NIOS2_OCI_TRACE_TSTAMP_EN
   logic [15:0] cyc_q;
   logic [15:0] ts_q;

   // Free-running cycle counter, captured as the frame timestamp on accept
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cyc_q <= '0;
         ts_q  <= '0;
      end else begin
         cyc_q <= cyc_q + 16'd1;
         if (accept) begin
            ts_q <= cyc_q;
         end
      end
   end

   assign wr_word = {ts_q, cur_slot};
`else
   assign wr_word = cur_slot;
`endif

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic plus frame, counter and sticky-flag updates
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      rem_d       = rem_q;
      idx_d       = idx_q;
      ending_d    = ending_req;
      count_err_d = count_err_q;
      drop_d      = drop_q;

      if (test_has_ended_i) begin
         // Abort wins over everything, including a frame in progress
         state_d = ST_DONE;
         rem_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ending_req) begin
                  state_d = ST_FLUSH;
               end else if (accept) begin
                  frame_d = dct_buffer_i;
                  rem_d   = clamp_cnt;
                  idx_d   = '0;
                  if (dct_count_i > CNT_MAX) begin
                     count_err_d = 1'b1;
                  end
                  // An empty frame is consumed without leaving IDLE
                  if (clamp_cnt != '0) begin
                     state_d = ST_UNPACK;
                  end
               end
            end
            ST_UNPACK: begin
               if (advance) begin
                  idx_d = idx_q + REM_W'(1);
                  rem_d = rem_q - REM_W'(1);
                  if (drop_slot && !(&drop_q)) begin
                     drop_d = drop_q + DROP_CNT_W'(1);
                  end
                  if (rem_q == REM_W'(1)) begin
                     state_d = ending_req ? ST_FLUSH : ST_IDLE;
                  end
               end
            end
            ST_FLUSH: begin
               if ((level_q == '0) && !trc_valid_q) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Frame holding registers, ending latch and status counters
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         frame_q     <= '0;
         rem_q       <= '0;
         idx_q       <= '0;
         ending_q    <= 1'b0;
         count_err_q <= 1'b0;
         drop_q      <= '0;
      end else begin
         frame_q     <= frame_d;
         rem_q       <= rem_d;
         idx_q       <= idx_d;
         ending_q    <= ending_d;
         count_err_q <= count_err_d;
         drop_q      <= drop_d;
      end
   end

   // Occupancy counts everything written and not yet handed to the consumer
   always_comb begin
      level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
   end

   // FIFO storage array; contents need no reset because level gates reads
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_word;
      end
   end

   // FIFO pointers and the registered head; an entry becomes visible one
   // cycle after it is written, and the head holds while the consumer stalls
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         trc_valid_q <= 1'b0;
         trc_data_q  <= '0;
      end else if (test_has_ended_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         trc_valid_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_next;
         end
         level_q <= level_d;
         if ((level_q - LVL_W'(rd_en)) != '0) begin
            trc_valid_q <= 1'b1;
            trc_data_q  <= mem_q[head_sel];
         end else begin
            trc_valid_q <= 1'b0;
         end
      end
   end

   assign trc_data_o   = trc_data_q;
   assign trc_valid_o  = trc_valid_q;
   assign drop_count_o = drop_q;
   assign count_err_o  = count_err_q;
   assign fifo_level_o = level_q;
   assign test_done_o  = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nios2_cpu_oci_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_cpu_oci_trace_monitor
// Purpose  : Directed self-checking bench for nios2_cpu_oci_trace_monitor.
//            u_dut stalls on a full FIFO, u_drp drops slots on a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_cpu_oci_trace_monitor;

   localparam int SLOT_W = 10;
   localparam int SLOTS  = 3;
   localparam int BUF_W  = SLOT_W * SLOTS;
   localparam int LVL_W  = 5;
`ifdef NIOS2_OCI_TRACE_TSTAMP_EN
   localparam int TRC_W  = SLOT_W + 16;
`else
   localparam int TRC_W  = SLOT_W;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [BUF_W-1:0] dct_buffer = '0;
   logic [3:0]       dct_count = '0;
   logic             dct_valid = 1'b0;
   logic             d_valid = 1'b0;
   logic             test_ending = 1'b0;
   logic             test_has_ended = 1'b0;
   logic             trc_ready = 1'b0;
   logic             d_trc_ready = 1'b0;

   logic             dct_ready, d_ready;
   logic [TRC_W-1:0] trc_data, d_data;
   logic             trc_valid, d_tvalid;
   logic [7:0]       drop_count, d_drop;
   logic             count_err, d_cerr;
   logic [LVL_W-1:0] fifo_level, d_level;
   logic             test_done, d_done;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int tb_cyc  = 0;

   nios2_cpu_oci_trace_monitor #(
      .SLOT_W(10), .SLOTS(3), .COUNT_W(4), .DEPTH(16),
      .DROP_ON_FULL(0), .DROP_CNT_W(8)
   ) u_dut (
      .clk_i(clk), .reset_i(reset),
      .dct_buffer_i(dct_buffer), .dct_count_i(dct_count),
      .dct_valid_i(dct_valid), .dct_ready_o(dct_ready),
      .test_ending_i(test_ending), .test_has_ended_i(test_has_ended),
      .trc_data_o(trc_data), .trc_valid_o(trc_valid), .trc_ready_i(trc_ready),
      .drop_count_o(drop_count), .count_err_o(count_err),
      .fifo_level_o(fifo_level), .test_done_o(test_done)
   );

   nios2_cpu_oci_trace_monitor #(
      .SLOT_W(10), .SLOTS(3), .COUNT_W(4), .DEPTH(16),
      .DROP_ON_FULL(1), .DROP_CNT_W(8)
   ) u_drp (
      .clk_i(clk), .reset_i(reset),
      .dct_buffer_i(dct_buffer), .dct_count_i(dct_count),
      .dct_valid_i(d_valid), .dct_ready_o(d_ready),
      .test_ending_i(1'b0), .test_has_ended_i(1'b0),
      .trc_data_o(d_data), .trc_valid_o(d_tvalid), .trc_ready_i(d_trc_ready),
      .drop_count_o(d_drop), .count_err_o(d_cerr),
      .fifo_level_o(d_level), .test_done_o(d_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      tb_cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one frame to the chosen instance and return just after its accept
   task automatic send(input bit drp, input logic [BUF_W-1:0] b, input logic [3:0] c);
      int n = 0;
      dct_buffer = b;
      dct_count  = c;
      if (drp) d_valid = 1'b1;
      else     dct_valid = 1'b1;
      #1;
      while (((drp ? d_ready : dct_ready) !== 1'b1) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         n_total++;
         n_fail++;
         $error("FAIL send_timeout: observed no dct_ready, expected ready within 100 cycles");
      end
      step();
      dct_valid = 1'b0;
      d_valid   = 1'b0;
   endtask

   // Enable the consumer and check the slots arrive as 1..n_exp in order
   task automatic drain(input bit drp, input int n_exp, input string tag);
      int got = 0;
      if (drp) d_trc_ready = 1'b1;
      else     trc_ready = 1'b1;
      #1;
      for (int i = 0; i < 60; i++) begin
         if ((drp ? d_tvalid : trc_valid) === 1'b1) begin
            if (got < n_exp) chk(tag, drp ? d_data[9:0] : trc_data[9:0], got + 1);
            got++;
         end
         step();
      end
      chk({tag, "_count"}, got, n_exp);
   endtask

   initial begin
      // Reset values
      step();
      step();
      chk("rst_ready", dct_ready, 0);
      chk("rst_valid", trc_valid, 0);
      chk("rst_data", trc_data, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_err", count_err, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_done", test_done, 0);
      reset = 1'b0;

      // Basic 3-slot frame with 2-cycle latency
      trc_ready  = 1'b1;
      dct_buffer = {10'h3FF, 10'h155, 10'h0AA};
      dct_count  = 4'd3;
      dct_valid  = 1'b1;
      #1;
      chk("A_ready", dct_ready, 1);
      step();
      dct_valid = 1'b0;
      chk("A_lat1", trc_valid, 0);
      step();
      chk("A_lat2", trc_valid, 0);
      step();
      chk("A_v0", trc_valid, 1);
      chk("A_d0", trc_data[9:0], 10'h0AA);
      chk("A_lvl", fifo_level, 2);
      step();
      chk("A_d1", trc_data[9:0], 10'h155);
      step();
      chk("A_d2", trc_data[9:0], 10'h3FF);
      step();
      chk("A_end_valid", trc_valid, 0);
      chk("A_end_lvl", fifo_level, 0);

      // Zero-count frame, then an over-long frame
      dct_buffer = {10'h2AB, 10'h2AB, 10'h2AB};
      dct_count  = 4'd0;
      dct_valid  = 1'b1;
      #1;
      chk("B_ready0", dct_ready, 1);
      step();
      dct_valid = 1'b0;
      step();
      step();
      chk("B_zero_valid", trc_valid, 0);
      chk("B_zero_lvl", fifo_level, 0);
      chk("B_err0", count_err, 0);
      dct_buffer = {10'h111, 10'h222, 10'h333};
      dct_count  = 4'd5;
      dct_valid  = 1'b1;
      #1;
      step();
      dct_valid = 1'b0;
      chk("B_err1", count_err, 1);
      step();
      step();
      chk("B_d0", trc_data[9:0], 10'h333);
      step();
      chk("B_d1", trc_data[9:0], 10'h222);
      step();
      chk("B_d2", trc_data[9:0], 10'h111);
      repeat (5) step();
      chk("B_err_sticky", count_err, 1);
      chk("B_end_valid", trc_valid, 0);

      // Stall on full FIFO
      trc_ready = 1'b0;
      for (int f = 0; f < 6; f++)
         send(1'b0, {10'(3*f+3), 10'(3*f+2), 10'(3*f+1)}, 4'd3);
      repeat (5) step();
      chk("C_lvl_full", fifo_level, 16);
      chk("C_ready_low", dct_ready, 0);
      chk("C_valid", trc_valid, 1);
      chk("C_drop", drop_count, 0);
      drain(1'b0, 18, "C_data");
      chk("C_lvl_end", fifo_level, 0);

      // Drop on full FIFO
      for (int f = 0; f < 6; f++)
         send(1'b1, {10'(3*f+3), 10'(3*f+2), 10'(3*f+1)}, 4'd3);
      repeat (5) step();
      chk("D_drop", d_drop, 2);
      chk("D_lvl_full", d_level, 16);
      chk("D_ready", d_ready, 1);
      drain(1'b1, 16, "D_data");
      chk("D_lvl_end", d_level, 0);

      // Graceful flush requested mid-frame
      dct_buffer = {10'h0C3, 10'h0B2, 10'h0A1};
      dct_count  = 4'd3;
      dct_valid  = 1'b1;
      #1;
      step();
      dct_valid = 1'b0;
      step();
      test_ending = 1'b1;
      step();
      chk("E_d0", trc_data[9:0], 10'h0A1);
      step();
      chk("E_d1", trc_data[9:0], 10'h0B2);
      step();
      chk("E_d2", trc_data[9:0], 10'h0C3);
      chk("E_ready_low", dct_ready, 0);
      chk("E_done_early", test_done, 0);
      step();
      chk("E_valid_end", trc_valid, 0);
      chk("E_done_wait", test_done, 0);
      step();
      chk("E_done", test_done, 1);
      chk("E_ready_done", dct_ready, 0);
      repeat (3) step();
      chk("E_done_hold", test_done, 1);

      // Abort with 10 entries queued, then reset
      test_ending = 1'b0;
      reset       = 1'b1;
      step();
      step();
      chk("F_rst_done", test_done, 0);
      chk("F_rst_err", count_err, 0);
      chk("F_rst_ready", dct_ready, 0);
      reset     = 1'b0;
      trc_ready = 1'b0;
      for (int f = 0; f < 3; f++)
         send(1'b0, {10'(3*f+3), 10'(3*f+2), 10'(3*f+1)}, 4'd3);
      send(1'b0, {10'h0, 10'h0, 10'h00A}, 4'd1);
      step();
      chk("F_lvl10", fifo_level, 10);
      chk("F_valid", trc_valid, 1);
      test_has_ended = 1'b1;
      step();
      test_has_ended = 1'b0;
      chk("F_abort_valid", trc_valid, 0);
      chk("F_abort_lvl", fifo_level, 0);
      chk("F_abort_done", test_done, 1);
      chk("F_abort_ready", dct_ready, 0);
      reset = 1'b1;
      step();
      step();
      chk("F_rst_valid", trc_valid, 0);
      chk("F_rst_data", trc_data, 0);
      chk("F_rst_drop", drop_count, 0);
      chk("F_rst_lvl", fifo_level, 0);
      chk("F_rst_done2", test_done, 0);
      chk("F_rst_ready2", dct_ready, 0);
      reset = 1'b0;
      step();
      chk("F_post_ready", dct_ready, 1);

`ifdef NIOS2_OCI_TRACE_TSTAMP_EN
      // Timestamps captured at accept cycles 5 and 20 after reset
      reset = 1'b1;
      step();
      reset     = 1'b0;
      tb_cyc    = 0;
      trc_ready = 1'b1;
      while (tb_cyc < 5) step();
      dct_buffer = {10'h0, 10'h022, 10'h011};
      dct_count  = 4'd2;
      dct_valid  = 1'b1;
      #1;
      step();
      dct_valid = 1'b0;
      step();
      step();
      chk("T_ts0a", trc_data[25:10], 16'd5);
      step();
      chk("T_ts0b", trc_data[25:10], 16'd5);
      while (tb_cyc < 20) step();
      dct_valid = 1'b1;
      #1;
      step();
      dct_valid = 1'b0;
      step();
      step();
      chk("T_ts1a", trc_data[25:10], 16'd20);
      step();
      chk("T_ts1b", trc_data[25:10], 16'd20);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
